// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the branch predictor: 2-bit counter
// encodings and the saturating counter update.
package branch_predictor_pkg;

  localparam int INST_ADDR_W = 32;

  localparam logic [1:0] BP_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] BP_WNT = 2'b01;  // weakly not-taken (reset value)
  localparam logic [1:0] BP_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] BP_ST  = 2'b11;  // strongly taken

  // Saturating 2-bit counter step: taken counts up to BP_ST, not-taken down to BP_SNT.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != BP_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != BP_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: valid/tag/target arrays with one
// combinational read port, one synchronous write port and a synchronous
// clear of the valid bits. Tags and targets are not reset; valid gates them.
module bp_btb
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic                   rd_valid,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [INST_ADDR_W-1:0] rd_target,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic [INST_ADDR_W-1:0] wr_target
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0]     valid_q;
  logic [TAG_W-1:0]       tag_q    [ENTRIES];
  logic [INST_ADDR_W-1:0] target_q [ENTRIES];

  // Read port: reflects registered state only, so a same-cycle write is not visible.
  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];

  // Valid bits: cleared on reset, set on write; entries are never invalidated otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/target storage: written alongside the valid bit, dropped while in reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Front-end branch predictor: 2-bit-counter BHT plus direct-mapped BTB,
// trained by resolved conditional branches from execute, with branch and
// misprediction performance counters.
//
// Update interface is valid-only (no ready): execute asserts upd_valid_i for
// exactly the cycles carrying a retiring result; the predictor always accepts
// it at that posedge and only conditional branches (upd_is_jmp_i) train it.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc_i,
  output logic             pred_jmp_o,
  output logic [31:0]      pred_target_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic             upd_is_jmp_i,
  input  logic             upd_taken_i,
  input  logic [31:0]      upd_dest_i,
  input  logic             upd_mispred_i,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             upd_en;
  logic             btb_valid;
  logic [TAG_W-1:0] btb_tag;
  logic [31:0]      btb_target;
  logic             hit;
  logic [31:0]      pc_plus4;
  logic [1:0]       bht [ENTRIES];

  // PC low bits are ignored: index from word address, tag from the bits above it.
  assign rd_idx = if_pc_i[IDX_W+1:2];
  assign rd_tag = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign wr_idx = upd_pc_i[IDX_W+1:2];
  assign wr_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Reset wins over a pending update; non-branch results never train.
  assign upd_en = upd_valid_i && upd_is_jmp_i && !rst;

  bp_btb #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (rd_idx),
    .rd_valid  (btb_valid),
    .rd_tag    (btb_tag),
    .rd_target (btb_target),
    .wr_en     (upd_en && upd_taken_i),
    .wr_idx    (wr_idx),
    .wr_tag    (wr_tag),
    .wr_target (upd_dest_i)
  );

  assign hit      = btb_valid && (btb_tag == rd_tag);
  assign pc_plus4 = if_pc_i + 32'd4;

  // Zero-latency lookup from registered state; outputs forced to fall-through in reset.
  always_comb begin
    pred_jmp_o    = 1'b0;
    pred_target_o = pc_plus4;
    if (!rst && hit && bht[rd_idx][1]) begin
      pred_jmp_o    = 1'b1;
      pred_target_o = btb_target;
    end
  end

  // BHT: all counters weakly not-taken on reset, saturating update on each branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= BP_WNT;
      end
    end else if (upd_en) begin
      bht[wr_idx] <= sat_update(bht[wr_idx], upd_taken_i);
    end
  end

  // Performance counters: retired conditional branches and their mispredictions (wrap).
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_o   <= '0;
      miss_cnt_o <= '0;
    end else if (upd_en) begin
      br_cnt_o <= br_cnt_o + CNT_W'(1);
      if (upd_mispred_i) begin
        miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a table of per-cycle vectors (update inputs,
// lookup PC, expected prediction and counters as seen before that cycle's
// update) plus a hand-written training sequence.
module tb_branch_predictor;

  localparam int W = 98;  // {chk_cnt, exp_jmp, exp_tgt[31:0], exp_br[31:0], exp_miss[31:0]}

  logic        clk;
  logic        rst;
  logic [31:0] if_pc_i;
  logic        pred_jmp_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_is_jmp_i;
  logic        upd_taken_i;
  logic [31:0] upd_dest_i;
  logic        upd_mispred_i;
  logic [31:0] br_cnt_o;
  logic [31:0] miss_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        uv;
    logic        uj;
    logic        ut;
    logic        um;
    logic [31:0] upc;
    logic [31:0] udest;
    logic [31:0] lpc;
    logic        e_jmp;
    logic [31:0] e_tgt;
    logic        chk_cnt;
    logic [31:0] e_br;
    logic [31:0] e_miss;
  } vec_t;

  vec_t vecs[$];

  branch_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc_i       (if_pc_i),
    .pred_jmp_o    (pred_jmp_o),
    .pred_target_o (pred_target_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_is_jmp_i  (upd_is_jmp_i),
    .upd_taken_i   (upd_taken_i),
    .upd_dest_i    (upd_dest_i),
    .upd_mispred_i (upd_mispred_i),
    .br_cnt_o      (br_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  // Clock: 10 time-unit period, posedge at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic uv, input logic uj, input logic ut,
                              input logic um, input logic [31:0] upc, input logic [31:0] udest,
                              input logic [31:0] lpc, input logic e_jmp, input logic [31:0] e_tgt,
                              input logic chk, input logic [31:0] e_br, input logic [31:0] e_miss);
    vec_t v;
    v.rst = r; v.uv = uv; v.uj = uj; v.ut = ut; v.um = um;
    v.upc = upc; v.udest = udest; v.lpc = lpc;
    v.e_jmp = e_jmp; v.e_tgt = e_tgt; v.chk_cnt = chk; v.e_br = e_br; v.e_miss = e_miss;
    return v;
  endfunction

  // One cycle: drive at negedge, push expectations, sample #1 later (before the posedge update).
  task automatic step(input vec_t v);
    logic [W-1:0] e;
    @(negedge clk);
    rst           = v.rst;
    upd_valid_i   = v.uv;
    upd_is_jmp_i  = v.uj;
    upd_taken_i   = v.ut;
    upd_mispred_i = v.um;
    upd_pc_i      = v.upc;
    upd_dest_i    = v.udest;
    if_pc_i       = v.lpc;
    exp_q.push_back({v.chk_cnt, v.e_jmp, v.e_tgt, v.e_br, v.e_miss});
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (pred_jmp_o !== e[96]) begin
      n_fail++;
      $display("FAIL pred_jmp pc=%h: got %b expected %b", if_pc_i, pred_jmp_o, e[96]);
    end
    n_tests++;
    if (pred_target_o !== e[95:64]) begin
      n_fail++;
      $display("FAIL pred_target pc=%h: got %h expected %h", if_pc_i, pred_target_o, e[95:64]);
    end
    if (e[97]) begin
      n_tests++;
      if (br_cnt_o !== e[63:32]) begin
        n_fail++;
        $display("FAIL br_cnt: got %0d expected %0d", br_cnt_o, e[63:32]);
      end
      n_tests++;
      if (miss_cnt_o !== e[31:0]) begin
        n_fail++;
        $display("FAIL miss_cnt: got %0d expected %0d", miss_cnt_o, e[31:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; if_pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0; upd_is_jmp_i = 1'b0;
    upd_taken_i = 1'b0; upd_dest_i = '0; upd_mispred_i = 1'b0;

    // Reset, then first training and lookup at 0x1000 (idx 0).
    vecs.push_back(mk(1,0,0,0,0, 32'h0,    32'h0,    32'h1000, 0, 32'h1004, 0, 0, 0));
    vecs.push_back(mk(0,1,1,1,1, 32'h1000, 32'h0F00, 32'h1000, 0, 32'h1004, 1, 0, 0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h1000, 1, 32'h0F00, 1, 1, 1));
    // Tag mismatch at the same index, and ignored low PC bits.
    vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h1100, 0, 32'h1104, 1, 1, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h1002, 1, 32'h0F00, 1, 1, 1));
    // Saturation at 0x2040 (idx 16): 4 taken, then 5 not-taken, then one taken.
    vecs.push_back(mk(0,1,1,1,1, 32'h2040, 32'h3000, 32'h2040, 0, 32'h2044, 1, 1, 1));
    vecs.push_back(mk(0,1,1,1,0, 32'h2040, 32'h3000, 32'h2040, 1, 32'h3000, 1, 2, 2));
    vecs.push_back(mk(0,1,1,1,0, 32'h2040, 32'h3000, 32'h2040, 1, 32'h3000, 1, 3, 2));
    vecs.push_back(mk(0,1,1,1,0, 32'h2040, 32'h3000, 32'h2040, 1, 32'h3000, 1, 4, 2));
    vecs.push_back(mk(0,1,1,0,1, 32'h2040, 32'h0,    32'h2040, 1, 32'h3000, 1, 5, 2));
    vecs.push_back(mk(0,1,1,0,0, 32'h2040, 32'h0,    32'h2040, 1, 32'h3000, 1, 6, 3));
    vecs.push_back(mk(0,1,1,0,0, 32'h2040, 32'h0,    32'h2040, 0, 32'h2044, 1, 7, 3));
    vecs.push_back(mk(0,1,1,0,0, 32'h2040, 32'h0,    32'h2040, 0, 32'h2044, 1, 8, 3));
    vecs.push_back(mk(0,1,1,0,0, 32'h2040, 32'h0,    32'h2040, 0, 32'h2044, 1, 9, 3));
    vecs.push_back(mk(0,1,1,1,1, 32'h2040, 32'h3000, 32'h2040, 0, 32'h2044, 1, 10, 3));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h2040, 0, 32'h2044, 1, 11, 4));
    // Filtering: invalid or non-branch updates must not train (counter stays 01, target 0x3000).
    vecs.push_back(mk(0,0,1,1,1, 32'h2040, 32'h5000, 32'h2040, 0, 32'h2044, 1, 11, 4));
    vecs.push_back(mk(0,1,0,1,1, 32'h2040, 32'h5000, 32'h2040, 0, 32'h2044, 1, 11, 4));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h2040, 0, 32'h2044, 1, 11, 4));
    // Same-cycle update and lookup: pre-update state this cycle, taken the next.
    vecs.push_back(mk(0,1,1,1,1, 32'h2040, 32'h3000, 32'h2040, 0, 32'h2044, 1, 11, 4));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h2040, 1, 32'h3000, 1, 12, 5));
    // Reset with a pending update: outputs forced, update dropped, everything cleared.
    vecs.push_back(mk(1,1,1,1,1, 32'h1000, 32'h0F00, 32'h1000, 0, 32'h1004, 1, 12, 5));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h1000, 0, 32'h1004, 1, 0, 0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h2040, 0, 32'h2044, 1, 0, 0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,    32'h0,    32'hFFFF_FFFC, 0, 32'h0000_0000, 1, 0, 0));

    foreach (vecs[i]) step(vecs[i]);

    // Hand sequence: retrain 0x1000 with changing targets, latest target wins;
    // a not-taken update leaves the BTB entry intact.
    step(mk(0,1,1,1,0, 32'h1000, 32'h0A00, 32'h1000, 0, 32'h1004, 1, 0, 0));
    step(mk(0,1,1,1,1, 32'h1000, 32'h0B00, 32'h1000, 1, 32'h0A00, 1, 1, 0));
    step(mk(0,1,1,0,1, 32'h1000, 32'h0,    32'h1000, 1, 32'h0B00, 1, 2, 1));
    step(mk(0,0,0,0,0, 32'h0,    32'h0,    32'h1000, 1, 32'h0B00, 1, 3, 2));

    // Randomised non-branch traffic on 0x1000: must never disturb the trained entry.
    for (int k = 0; k < 8; k++) begin
      step(mk(0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'h1000, $urandom, 32'h1000, 1, 32'h0B00, 1, 3, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
